// File: rtl/midi_note_parser.sv
// midi_note_parser: MIDI byte parser with running status, note events and a monophonic held-note/gate.
module midi_note_parser #(
  parameter bit         OMNI       = 1'b1,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter logic [6:0] RESET_NOTE = 7'd60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       event_valid,
  output logic       event_on,
  output logic [6:0] event_note,
  output logic [6:0] event_vel,
  output logic       gate,
  output logic [6:0] held_note,
  output logic [6:0] held_vel,
  output logic       err_pulse
);
  typedef enum logic [1:0] {S_NONE, S_D1, S_D2, S_SYSEX} state_t;
  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic       ev_q, ev_d, on_q, on_d, gate_q, gate_d, err_q, err_d;
  logic [6:0] note_q, note_d, vel_q, vel_d, hn_q, hn_d, hv_q, hv_d;
  logic       is_data, is_chan, is_rt, two_byte, chan_ok, hit, note_on;
  assign is_rt    = rx_byte[7:3] == 5'b11111;
  assign is_data  = rx_valid && !rx_byte[7];
  assign is_chan  = rx_valid && rx_byte[7] && rx_byte[7:4] != 4'hF;
  // Cx and Dx carry a single data byte; every other channel status carries two.
  assign two_byte = status_q[6:5] != 2'b10;
  assign chan_ok  = OMNI || status_q[3:0] == CHANNEL;
  assign hit      = is_data && state_q == S_D2 && status_q[7:5] == 3'b100 && chan_ok;
  assign note_on  = status_q[4] && |rx_byte[6:0];
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    ev_d     = 1'b0;
    err_d    = 1'b0;
    on_d     = on_q;
    note_d   = note_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    hn_d     = hn_q;
    hv_d     = hv_q;
    if (is_data) begin
      err_d = state_q == S_NONE;
      if (state_q == S_D1 && two_byte) begin
        d1_d    = rx_byte[6:0];
        state_d = S_D2;
      end
      if (state_q == S_D2) state_d = S_D1;
    end else if (is_chan) begin
      status_d = rx_byte;
      state_d  = S_D1;
    end else if (rx_valid && !is_rt) begin
      status_d = 8'h00;
      state_d  = rx_byte == 8'hF0 ? S_SYSEX : S_NONE;
    end
    if (hit) begin
      ev_d   = 1'b1;
      on_d   = note_on;
      note_d = d1_q;
      vel_d  = rx_byte[6:0];
      if (note_on) begin
        hn_d   = d1_q;
        hv_d   = rx_byte[6:0];
        gate_d = 1'b1;
      end else if (gate_q && d1_q == hn_q) gate_d = 1'b0;
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_NONE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      ev_q     <= 1'b0;
      on_q     <= 1'b0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      gate_q   <= 1'b0;
      hn_q     <= RESET_NOTE;
      hv_q     <= 7'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      ev_q     <= ev_d;
      on_q     <= on_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      hn_q     <= hn_d;
      hv_q     <= hv_d;
      err_q    <= err_d;
    end
  end
  assign event_valid = ev_q;
  assign event_on    = on_q;
  assign event_note  = note_q;
  assign event_vel   = vel_q;
  assign gate        = gate_q;
  assign held_note   = hn_q;
  assign held_vel    = hv_q;
  assign err_pulse   = err_q;
endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser: directed checks of an omni parser and a channel-2-only parser sharing one byte stream.
module tb_midi_note_parser;
  logic       Clk = 1'b0, Reset = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       a_ev, a_on, a_gate, a_err, b_ev, b_on, b_gate, b_err;
  logic [6:0] a_note, a_vel, a_hn, a_hv, b_note, b_vel, b_hn, b_hv;
  int         tests = 0, fails = 0;
  always #5 Clk = ~Clk;
  midi_note_parser #(.OMNI(1'b1), .CHANNEL(4'd0), .RESET_NOTE(7'd60)) dut_a (
    .Clk(Clk), .Reset(Reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .event_valid(a_ev), .event_on(a_on), .event_note(a_note), .event_vel(a_vel),
    .gate(a_gate), .held_note(a_hn), .held_vel(a_hv), .err_pulse(a_err));
  midi_note_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .RESET_NOTE(7'd60)) dut_b (
    .Clk(Clk), .Reset(Reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .event_valid(b_ev), .event_on(b_on), .event_note(b_note), .event_vel(b_vel),
    .gate(b_gate), .held_note(b_hn), .held_vel(b_hv), .err_pulse(b_err));
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Called at a falling edge; returns at the next falling edge with the byte's registered results visible.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge Clk);
    rx_valid = 1'b0;
  endtask
  initial begin
    @(negedge Clk);
    chk("rst_ev", a_ev, 0);
    chk("rst_gate", a_gate, 0);
    chk("rst_hn", a_hn, 60);
    chk("rst_hv", a_hv, 0);
    chk("rst_err", a_err, 0);
    chk("rst_note", a_note, 0);
    Reset = 1'b0;
    @(negedge Clk);
    send(8'h90); send(8'h3C);
    chk("t1_noev", a_ev, 0);
    send(8'h64);
    chk("t1_ev", a_ev, 1);
    chk("t1_on", a_on, 1);
    chk("t1_note", a_note, 60);
    chk("t1_vel", a_vel, 100);
    chk("t1_gate", a_gate, 1);
    chk("t1_hn", a_hn, 60);
    chk("t1_hv", a_hv, 100);
    @(negedge Clk);
    chk("t1_pulse", a_ev, 0);
    send(8'h90); send(8'h40); send(8'h50);
    chk("rs_ev1", a_ev, 1);
    chk("rs_note1", a_note, 64);
    send(8'h43);
    chk("rs_mid", a_ev, 0);
    send(8'h50);
    chk("rs_ev2", a_ev, 1);
    chk("rs_note2", a_note, 67);
    chk("rs_hn", a_hn, 67);
    chk("rs_gate", a_gate, 1);
    send(8'h43); send(8'h00);
    chk("rs_off_ev", a_ev, 1);
    chk("rs_off_on", a_on, 0);
    chk("rs_off_note", a_note, 67);
    chk("rs_off_gate", a_gate, 0);
    chk("rs_off_hn", a_hn, 67);
    chk("rs_off_hv", a_hv, 80);
    send(8'h90); send(8'h3C); send(8'h64);
    chk("nm_gate_on", a_gate, 1);
    send(8'h80); send(8'h40); send(8'h00);
    chk("nm_ev", a_ev, 1);
    chk("nm_on", a_on, 0);
    chk("nm_note", a_note, 64);
    chk("nm_gate", a_gate, 1);
    chk("nm_hn", a_hn, 60);
    send(8'h80); send(8'h3C); send(8'h40);
    chk("m_off_gate", a_gate, 0);
    chk("m_off_vel", a_vel, 64);
    chk("m_off_hn", a_hn, 60);
    send(8'h90); send(8'h3C); send(8'hF8);
    chk("rt_noev", a_ev, 0);
    send(8'h64);
    chk("rt_ev", a_ev, 1);
    chk("rt_note", a_note, 60);
    chk("rt_vel", a_vel, 100);
    send(8'hF0); send(8'h3C); send(8'h40);
    chk("sx_ev", a_ev, 0);
    chk("sx_err", a_err, 0);
    send(8'hF7);
    chk("sx_hold_note", a_note, 60);
    send(8'h3E);
    chk("sx_err3e", a_err, 1);
    chk("sx_noev3e", a_ev, 0);
    send(8'h10);
    chk("sx_noev10", a_ev, 0);
    send(8'h91); send(8'h3C); send(8'h64);
    chk("ch_other", b_ev, 0);
    chk("ch_omni", a_ev, 1);
    send(8'h92); send(8'h3C); send(8'h64);
    chk("ch_match", b_ev, 1);
    chk("ch_match_note", b_note, 60);
    chk("ch_match_gate", b_gate, 1);
    send(8'hC2); send(8'h05);
    chk("cx_ev", b_ev, 0);
    chk("cx_err", b_err, 0);
    send(8'h48);
    chk("cx_run_ev", b_ev, 0);
    chk("cx_run_err", b_err, 0);
    send(8'h90); send(8'h3C);
    Reset = 1'b1;
    #1;
    chk("mr_async_gate", a_gate, 0);
    chk("mr_async_hn", a_hn, 60);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    send(8'h64);
    chk("mr_noev", a_ev, 0);
    chk("mr_err", a_err, 1);
    chk("mr_gate", a_gate, 0);
    chk("mr_hn", a_hn, 60);
    @(negedge Clk);
    chk("mr_err_pulse", a_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Byte-level MIDI channel-message parser between the UART receiver and the note display/synth stages.
- Consumes received MIDI bytes, tracks status and running status, and emits note-on/note-off events.
- Maintains a monophonic "held note" register. held_note drives the MIDI_freq input of the downstream note-name/octave decoder and the oscillator pitch select.
- Also drives a gate signal for the envelope.

Parameters:
- OMNI, 1: 1 = accept note messages on all 16 channels; 0 = accept only CHANNEL.
- CHANNEL, 4'd0: MIDI channel (0-15) accepted when OMNI=0.
- RESET_NOTE, 7'd60: held_note value after reset (C4).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rx_byte  in  8  received MIDI byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back strobes allowed.
- event_valid  out  1  one-cycle pulse: a note event was decoded.
- event_on  out  1  1 = note-on, 0 = note-off; valid with event_valid.
- event_note  out  7  note number of the event.
- event_vel  out  7  velocity of the event (raw; 0 for note-on-with-vel-0).
- gate  out  1  high while held note is sounding.
- held_note  out  7  most recent note-on number.
- held_vel  out  7  velocity of the most recent note-on.
- err_pulse  out  1  one-cycle pulse: data byte received with no running status.

Behaviour:
- Reset (async, any time, mid-message included):
  - State -> S_NONE; running status cleared.
  - event_valid, event_on, event_note, event_vel, gate, err_pulse = 0.
  - held_note = RESET_NOTE; held_vel = 0.
- Byte classes:
  - data = bit7 0.
  - channel status = 8x-Ex.
  - SysEx start = F0.
  - system common = F1-F7.
  - realtime = F8-FF.
- Message lengths:
  - 8x, 9x, Ax, Bx, Ex: 2 data bytes.
  - Cx, Dx: 1 data byte.
- Registers: status (8b), d1 (7b), state in {S_NONE, S_D1, S_D2, S_SYSEX}.
- Realtime bytes (F8-FF): ignored completely in every state. No state, status, or output change; an in-progress message continues unaffected.
- Channel status byte, any state (terminates SysEx): status <= byte, state -> S_D1.
- F0: clear status, state -> S_SYSEX.
- F1-F7: clear status, state -> S_NONE. F7 while in S_SYSEX ends SysEx the same way.
- Data byte handling by state:
  - S_NONE: ignored; err_pulse=1 next cycle.
  - S_SYSEX: ignored silently.
  - S_D1, 2-byte message: d1 <= byte, state -> S_D2.
  - S_D1, 1-byte message: message complete, stay in S_D1 (running status).
  - S_D2: message complete, state -> S_D1 (running status retained).
- Completion with status 8x/9x and channel accepted (OMNI=1, or status[3:0]==CHANNEL):
  - event_valid=1 on the cycle after the completing rx_valid (registered, latency 1).
  - event_note = d1; event_vel = data byte 2.
  - event_on = 1 only if status is 9x and vel != 0. 8x, or 9x with vel=0, is note-off.
- All other completed messages (other channel, Ax/Bx/Cx/Dx/Ex): no event, no err.
- event_note, event_vel, event_on hold their last values between pulses.
- Held-note/gate update, same cycle as event_valid:
  - note-on: held_note<=note, held_vel<=vel, gate<=1. Applies even if gate already 1 (last-note priority, legato).
  - note-off with note==held_note and gate=1: gate<=0; held_note and held_vel retained.
  - note-off for any other note: no change.
- Simultaneous events: only one rx_valid per cycle, so at most one event per cycle. err_pulse and event_valid are never both 1.

Test Plan:
- Reset, then 90 3C 64 -> one event_valid 1 cycle after the 3rd byte: on=1, note=60, vel=100; gate=1, held_note=60, held_vel=100.
- Running status: 90 40 50 43 50 -> two note-on events (note 64 then 67); held_note=67, gate=1. Then 43 00 -> note-off event, gate=0, held_note stays 67.
- Non-matching off: after 90 3C 64, send 80 40 00 -> event on=0 note=64; gate stays 1, held_note=60. Then 80 3C 40 -> gate=0.
- Realtime/SysEx: 90 3C F8 64 -> single note-on note=60 vel=100. Then F0 3C 40 F7 3E 10 -> no event; err_pulse on byte 3E (status cleared); 10 ignored.
- Channel filter (OMNI=0, CHANNEL=2): 91 3C 64 -> no event; 92 3C 64 -> event; C2 05 then 48 -> no event, no err (running Cx).
- Reset mid-message: 90 3C, assert Reset, release, send 64 -> no event, err_pulse=1; gate=0, held_note=60.
